// File: rtl/uart_rx_axis_if.sv
// AXI-Stream style beat channel carried out of the UART receiver.
// The master drives data/valid and the slave returns ready.
interface uart_rx_axis_if #(
  parameter int W_OUT = 16
);
  logic [W_OUT-1:0] m_data;
  logic             m_valid;
  logic             m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/uart_rx_axis.sv
// UART receiver with mid-bit sampling, optional parity and 1/2 stop bits.
// Received words are packed into W_OUT-wide beats and queued in a show-ahead FIFO.
module uart_rx_axis #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int W_OUT            = 16,
  parameter int PARITY           = 0,
  parameter int STOP_BITS        = 1,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               rx,
  uart_rx_axis_if.master     m_axis,
  output logic               frame_err,
  output logic               parity_err,
  output logic               overrun
);
  localparam int NUM_WORDS = W_OUT / BITS_PER_WORD;
  localparam int CW        = $clog2(CLOCKS_PER_PULSE);
  localparam int BW        = $clog2(BITS_PER_WORD + 1);
  localparam int IW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int AW        = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                   state_q, state_d;
  logic                     rx_meta_q, rx_s_q;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [BW-1:0]            bit_q, bit_d;
  logic [BITS_PER_WORD-1:0] shift_q, shift_d;
  logic                     ferr_q, ferr_d;
  logic                     perr_q, perr_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [BITS_PER_WORD-1:0] slot_q [NUM_WORDS];
  logic [BITS_PER_WORD-1:0] slot_d [NUM_WORDS];
  logic                     frame_err_q, frame_err_d;
  logic                     parity_err_q, parity_err_d;
  logic                     overrun_q, overrun_d;
  logic [AW:0]              wr_q, wr_d, rd_q, rd_d;
  logic [W_OUT-1:0]         mem_q [FIFO_DEPTH];

  logic             half_tick, tick, last_bit, last_stop, exp_par;
  logic             word_done, fe_now, pe_now, push, do_push, pop, full, empty;
  logic [W_OUT-1:0] beat;

  assign half_tick = (cnt_q == CW'(CLOCKS_PER_PULSE / 2 - 1));
  assign tick      = (cnt_q == CW'(CLOCKS_PER_PULSE - 1));
  assign last_bit  = (bit_q == BW'(BITS_PER_WORD - 1));
  assign last_stop = (bit_q == BW'(STOP_BITS - 1));
  assign exp_par   = (PARITY == 1) ? ~^shift_q : ^shift_q;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s_q) state_d = S_START;
      S_START: if (half_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:  if (tick && last_bit) state_d = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (tick) state_d = S_STOP;
      S_STOP:  if (tick && last_stop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bit timing, shifting and per-frame error capture
  always_comb begin
    cnt_d     = cnt_q + CW'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    word_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        ferr_d = 1'b0;
        perr_d = 1'b0;
      end
      S_START: if (half_tick) cnt_d = '0;
      S_DATA: if (tick) begin
        cnt_d                    = '0;
        shift_d                  = shift_q >> 1;
        shift_d[BITS_PER_WORD-1] = rx_s_q;
        bit_d                    = last_bit ? '0 : bit_q + BW'(1);
      end
      S_PAR: if (tick) begin
        cnt_d  = '0;
        perr_d = (rx_s_q != exp_par);
      end
      S_STOP: if (tick) begin
        cnt_d = '0;
        if (!rx_s_q) ferr_d = 1'b1;
        if (last_stop) begin
          word_done = 1'b1;
          bit_d     = '0;
        end else begin
          bit_d = bit_q + BW'(1);
        end
      end
      default: cnt_d = '0;
    endcase
  end

  // The final stop sample counts toward the frame error in the same cycle
  assign fe_now = ferr_q | ~rx_s_q;
  assign pe_now = perr_q;

  // The newest word goes straight into the top slot of the beat
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_beat
    if (gi == NUM_WORDS - 1) begin : g_last
      assign beat[gi*BITS_PER_WORD +: BITS_PER_WORD] = shift_q;
    end else begin : g_slot
      assign beat[gi*BITS_PER_WORD +: BITS_PER_WORD] = slot_q[gi];
    end
  end

  always_comb begin
    slot_d       = slot_q;
    idx_d        = idx_q;
    push         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (word_done) begin
      if (fe_now || pe_now) begin
        idx_d        = '0;
        frame_err_d  = fe_now;
        parity_err_d = pe_now;
      end else if (idx_q == IW'(NUM_WORDS - 1)) begin
        idx_d = '0;
        push  = 1'b1;
      end else begin
        slot_d[idx_q] = shift_q;
        idx_d         = idx_q + IW'(1);
      end
    end
  end

  // Output FIFO: pointers carry one extra wrap bit to tell full from empty
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && m_axis.m_ready;
  assign do_push = push && (!full || pop);

  always_comb begin
    overrun_d = push && full && !pop;
    wr_d      = wr_q + (AW+1)'(do_push);
    rd_d      = rd_q + (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= beat;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      idx_q        <= '0;
      for (int i = 0; i < NUM_WORDS; i++) slot_q[i] <= '0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      wr_q         <= '0;
      rd_q         <= '0;
    end else begin
      rx_meta_q    <= rx;
      rx_s_q       <= rx_meta_q;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      idx_q        <= idx_d;
      slot_q       <= slot_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
    end
  end

  // Gate data so stale RAM contents never show while the FIFO is empty
  assign m_axis.m_valid = !empty;
  assign m_axis.m_data  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign frame_err      = frame_err_q;
  assign parity_err     = parity_err_q;
  assign overrun        = overrun_q;
endmodule
